// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, sequencer states
// and the one-hot ALU operation bit positions also used by the datapath ALU.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int ALU_W    = 13;
    localparam int ALU_AND  = 0;
    localparam int ALU_OR   = 1;
    localparam int ALU_ADD  = 2;
    localparam int ALU_SUB  = 3;
    localparam int ALU_MUL  = 4;
    localparam int ALU_DIV  = 5;
    localparam int ALU_SHR  = 6;
    localparam int ALU_SHRA = 7;
    localparam int ALU_SHL  = 8;
    localparam int ALU_ROR  = 9;
    localparam int ALU_ROL  = 10;
    localparam int ALU_NEG  = 11;
    localparam int ALU_NOT  = 12;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
    } state_e;

    function automatic logic is_rfmt(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_SHL);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic [ALU_W-1:0] alu_onehot(input logic [4:0] op);
        logic [ALU_W-1:0] v;
        v = '0;
        case (op)
            OP_AND:  v[ALU_AND]  = 1'b1;
            OP_OR:   v[ALU_OR]   = 1'b1;
            OP_ADD:  v[ALU_ADD]  = 1'b1;
            OP_SUB:  v[ALU_SUB]  = 1'b1;
            OP_MUL:  v[ALU_MUL]  = 1'b1;
            OP_DIV:  v[ALU_DIV]  = 1'b1;
            OP_SHR:  v[ALU_SHR]  = 1'b1;
            OP_SHRA: v[ALU_SHRA] = 1'b1;
            OP_SHL:  v[ALU_SHL]  = 1'b1;
            OP_ROR:  v[ALU_ROR]  = 1'b1;
            OP_ROL:  v[ALU_ROL]  = 1'b1;
            OP_NEG:  v[ALU_NEG]  = 1'b1;
            OP_NOT:  v[ALU_NOT]  = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Picks the Ra/Rb/Rc field of the IR and turns it into one-hot register
// load (Rin) and bus-drive (Rout) enables.
module reg_select_decoder #(
    parameter int NREG = 16
) (
    input  logic [31:0]     IR,
    input  logic            Gra,
    input  logic            Grb,
    input  logic            Grc,
    input  logic            Rin_en,
    input  logic            Rout_en,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout
);

    logic [3:0]      sel;
    logic [NREG-1:0] onehot;
    logic            unused_ir;

    assign sel    = ({4{Gra}} & IR[26:23]) | ({4{Grb}} & IR[22:19]) | ({4{Grc}} & IR[18:15]);
    assign onehot = {{(NREG-1){1'b0}}, 1'b1} << sel;
    assign Rin    = Rin_en  ? onehot : '0;
    assign Rout   = Rout_en ? onehot : '0;

    assign unused_ir = ^{IR[31:27], IR[14:0]};

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch, decode and per-class execute steps,
// with strobes decoded from the present state and the IR fields.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int NREG = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IR,
    input  logic             stop,
    output logic [NREG-1:0]  Rin,
    output logic [NREG-1:0]  Rout,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             Read,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             HIin,
    output logic             LOin,
    output logic             HIout,
    output logic             LOout,
    output logic [ALU_W-1:0] alu_op,
    output logic             run
);

    state_e         state_q, state_d;
    logic [OPW-1:0] op;
    logic           c_rfmt, c_md, c_un;
    logic           Gra, Grb, Grc, Rin_en, Rout_en;
    state_e         end_state;

    assign op     = IR[31:32-OPW];
    assign c_rfmt = is_rfmt(op);
    assign c_md   = is_muldiv(op);
    assign c_un   = is_unary(op);

    // stop only matters on the edge that leaves the final step of an instruction
    assign end_state = stop ? ST_HALT : ST_T0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_RST;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:  state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                if (c_rfmt || c_md || c_un) state_d = ST_T4;
                else if (op == OP_HALT)      state_d = ST_HALT;
                else                         state_d = end_state;
            end
            ST_T4:   state_d = c_un ? end_state : ST_T5;
            ST_T5:   state_d = c_md ? ST_T6 : end_state;
            ST_T6:   state_d = end_state;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
        HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0;
        alu_op = '0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin_en = 1'b0; Rout_en = 1'b0;
        case (state_q)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
                if (c_rfmt) begin
                    Grb = 1'b1; Rout_en = 1'b1; Yin = 1'b1;
                end else if (c_md) begin
                    Gra = 1'b1; Rout_en = 1'b1; Yin = 1'b1;
                end else if (c_un) begin
                    Grb = 1'b1; Rout_en = 1'b1; alu_op = alu_onehot(op); Zin = 1'b1;
                end
            end
            ST_T4: begin
                if (c_rfmt) begin
                    Grc = 1'b1; Rout_en = 1'b1; alu_op = alu_onehot(op); Zin = 1'b1;
                end else if (c_md) begin
                    Grb = 1'b1; Rout_en = 1'b1; alu_op = alu_onehot(op); Zin = 1'b1;
                end else if (c_un) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin_en = 1'b1;
                end
            end
            ST_T5: begin
                if (c_rfmt) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin_en = 1'b1;
                end else if (c_md) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end
            end
            ST_T6: begin
                if (c_md) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign run = (state_q != ST_RST) && (state_q != ST_HALT);

    reg_select_decoder #(.NREG(NREG)) u_regsel (
        .IR      (IR),
        .Gra     (Gra),
        .Grb     (Grb),
        .Grc     (Grc),
        .Rin_en  (Rin_en),
        .Rout_en (Rout_en),
        .Rin     (Rin),
        .Rout    (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class cycle by
// cycle and compares every strobe against hand-written expectations.
module tb_control_sequencer;

    logic        clk, reset, stop;
    logic [31:0] IR;
    logic [15:0] Rin, Rout;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
    logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout;
    logic [12:0] alu_op;
    logic        run;

    int n_cmp = 0;
    int n_bad = 0;

    // strobe bit positions inside the packed 16-bit strobe word
    localparam logic [15:0] S_PCOUT = 16'h8000, S_PCIN = 16'h4000, S_INCPC = 16'h2000;
    localparam logic [15:0] S_MARIN = 16'h1000, S_MDRIN = 16'h0800, S_MDROUT = 16'h0400;
    localparam logic [15:0] S_READ = 16'h0200, S_IRIN = 16'h0100, S_YIN = 16'h0080;
    localparam logic [15:0] S_ZIN = 16'h0040, S_ZHI = 16'h0020, S_ZLO = 16'h0010;
    localparam logic [15:0] S_HIIN = 16'h0008, S_LOIN = 16'h0004;

    localparam logic [15:0] E_T0 = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
    localparam logic [15:0] E_T1 = S_ZLO | S_PCIN | S_READ | S_MDRIN;
    localparam logic [15:0] E_T2 = S_MDROUT | S_IRIN;

    control_sequencer dut (
        .clk(clk), .reset(reset), .IR(IR), .stop(stop),
        .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
        .alu_op(alu_op), .run(run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [61:0] ev(input logic [15:0] rin, input logic [15:0] rout,
                                       input logic [15:0] s, input logic [12:0] alu,
                                       input logic r);
        return {rin, rout, s, alu, r};
    endfunction

    task automatic chk(input string tag, input logic [61:0] exp);
        logic [61:0] obs;
        obs = {Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
               Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, alu_op, run};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag);
        chk({tag, "_T0"}, ev('0, '0, E_T0, '0, 1'b1)); step();
        chk({tag, "_T1"}, ev('0, '0, E_T1, '0, 1'b1)); step();
        chk({tag, "_T2"}, ev('0, '0, E_T2, '0, 1'b1)); step();
    endtask

    initial begin
        reset = 1'b0; stop = 1'b0; IR = 32'h0;
        #2;
        chk("reset", ev('0, '0, '0, '0, 1'b0));
        #10 reset = 1'b1;
        step();

        // OR R4 = R3 | R7
        IR = 32'h321B8000;
        fetch("or");
        chk("or_T3", ev('0, 16'h0008, S_YIN, '0, 1'b1)); step();
        chk("or_T4", ev('0, 16'h0080, S_ZIN, 13'h0002, 1'b1)); step();
        chk("or_T5", ev(16'h0010, '0, S_ZLO, '0, 1'b1)); step();

        // ADD R1 = R2 + R3
        IR = 32'h18918000;
        fetch("add");
        chk("add_T3", ev('0, 16'h0004, S_YIN, '0, 1'b1)); step();
        chk("add_T4", ev('0, 16'h0008, S_ZIN, 13'h0004, 1'b1)); step();
        chk("add_T5", ev(16'h0002, '0, S_ZLO, '0, 1'b1)); step();

        // MUL R5 * R6
        IR = 32'h82B00000;
        fetch("mul");
        chk("mul_T3", ev('0, 16'h0020, S_YIN, '0, 1'b1)); step();
        chk("mul_T4", ev('0, 16'h0040, S_ZIN, 13'h0010, 1'b1)); step();
        chk("mul_T5", ev('0, '0, S_ZLO | S_LOIN, '0, 1'b1)); step();
        chk("mul_T6", ev('0, '0, S_ZHI | S_HIIN, '0, 1'b1)); step();

        // NEG R2 = -R9
        IR = 32'h89480000;
        fetch("neg");
        chk("neg_T3", ev('0, 16'h0200, S_ZIN, 13'h0800, 1'b1)); step();
        chk("neg_T4", ev(16'h0004, '0, S_ZLO, '0, 1'b1)); step();

        // undefined opcode is a one-step NOP
        IR = 32'hF8000000;
        fetch("nop");
        chk("nop_T3", ev('0, '0, '0, '0, 1'b1)); step();

        // stop raised mid-ADD must not truncate it
        IR = 32'h18918000;
        fetch("stp");
        chk("stp_T3", ev('0, 16'h0004, S_YIN, '0, 1'b1)); step();
        stop = 1'b1;
        chk("stp_T4", ev('0, 16'h0008, S_ZIN, 13'h0004, 1'b1)); step();
        chk("stp_T5", ev(16'h0002, '0, S_ZLO, '0, 1'b1)); step();
        chk("stp_halt", ev('0, '0, '0, '0, 1'b0)); step();
        stop = 1'b0;
        step();
        chk("stp_halt2", ev('0, '0, '0, '0, 1'b0));

        reset = 1'b0;
        #2 chk("rst2", ev('0, '0, '0, '0, 1'b0));
        #2 reset = 1'b1;
        step();

        // HALT instruction is absorbing
        IR = 32'hD8000000;
        fetch("hlt");
        chk("hlt_T3", ev('0, '0, '0, '0, 1'b1)); step();
        for (int i = 0; i < 10; i++) begin
            chk("hlt_stay", ev('0, '0, '0, '0, 1'b0)); step();
        end

        reset = 1'b0;
        #2 reset = 1'b1;
        step();

        // reset asserted during T4 aborts the ADD at once
        IR = 32'h18918000;
        fetch("abt");
        chk("abt_T3", ev('0, 16'h0004, S_YIN, '0, 1'b1)); step();
        reset = 1'b0;
        #1 chk("abt_rst", ev('0, '0, '0, '0, 1'b0));
        step();
        chk("abt_held", ev('0, '0, '0, '0, 1'b0));
        #2 reset = 1'b1;
        step();
        chk("abt_T0", ev('0, '0, E_T0, '0, 1'b1)); step();
        chk("abt_T1", ev('0, '0, E_T1, '0, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
